// File: rtl/tsbus_drv_ctrl.sv
// Sequencer for a notif1 tristate inverter bank driving a shared bus line:
// data setup, enable hold window, readback check at drive end, then a release gap.
module tsbus_drv_ctrl #(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] drv_in,
    output logic             drv_en,
    output logic             busy,
    output logic             ack,
    output logic             err
);

    localparam int CMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2((CMAX > 2) ? CMAX : 2);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] drv_in_q, drv_in_d;
    logic             drv_en_q, drv_en_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        drv_in_d = drv_in_q;
        drv_en_d = drv_en_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    data_d   = wdata;
                    drv_in_d = ~wdata;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                drv_en_d = 1'b1;
                cnt_d    = HOLD_LD;
                state_d  = S_DRIVE;
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    // Readback is taken on the same edge the enable drops.
                    drv_en_d = 1'b0;
                    ack_d    = 1'b1;
                    err_d    = (bus_in != data_q);
                    if (GAP_CYC > 0) begin
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async reset clears drv_en without a clock so the bus is released at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            drv_in_q <= '0;
            drv_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            drv_in_q <= drv_in_d;
            drv_en_q <= drv_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign drv_in = drv_in_q;
    assign drv_en = drv_en_q;
    assign busy   = busy_q;
    assign ack    = ack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_tsbus_drv_ctrl.sv
// Scoreboard bench: two controllers (gap 2 and gap 0) against a timeline model
// that derives every output from the acceptance edge of the current transfer.
module tb_tsbus_drv_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         fault = 1'b0;
    logic [W-1:0] fval = '0;

    logic [W-1:0] din_a, din_b, bus_a, bus_b;
    logic         en_a, busy_a, ack_a, err_a;
    logic         en_b, busy_b, ack_b, err_b;

    // Resolved bus: the inverter stage inverts drv_in when enabled, unless a fault overrides it.
    assign bus_a = fault ? fval : (en_a ? ~din_a : '0);
    assign bus_b = fault ? fval : (en_b ? ~din_b : '0);

    tsbus_drv_ctrl #(.WIDTH(W), .HOLD_CYC(H), .GAP_CYC(G)) dut_a (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .bus_in(bus_a),
        .drv_in(din_a), .drv_en(en_a), .busy(busy_a), .ack(ack_a), .err(err_a));

    tsbus_drv_ctrl #(.WIDTH(W), .HOLD_CYC(H), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .bus_in(bus_b),
        .drv_in(din_b), .drv_en(en_b), .busy(busy_b), .ack(ack_b), .err(err_b));

    always #10 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] din;
        logic         en;
        logic         busy;
        logic         ack;
        logic         err;
    } obs_t;

    typedef struct {
        bit           act;
        longint       k;
        logic [W-1:0] data;
        logic [W-1:0] din;
    } mdl_t;

    mdl_t   m [2];
    obs_t   qa[$];
    obs_t   qb[$];
    int     passed = 0;
    int     total = 0;
    longint edge_n = 0;

    logic         req_s;
    logic [W-1:0] wd_s, bus_a_s, bus_b_s;

    always @(negedge clk) begin
        req_s   = req;
        wd_s    = wdata;
        bus_a_s = bus_a;
        bus_b_s = bus_b;
    end

    function automatic obs_t step(int idx, int gap, longint e, logic rq, logic [W-1:0] wd,
                                  logic [W-1:0] bus);
        obs_t o;
        bit   idle;
        idle = !m[idx].act || (e > m[idx].k + 1 + H + gap);
        if (idle && rq) begin
            m[idx].act  = 1'b1;
            m[idx].k    = e;
            m[idx].data = wd;
            m[idx].din  = ~wd;
        end
        o.din  = m[idx].din;
        o.en   = m[idx].act && (e >= m[idx].k + 1) && (e < m[idx].k + 1 + H);
        o.ack  = m[idx].act && (e == m[idx].k + 1 + H);
        o.err  = o.ack && (bus != m[idx].data);
        o.busy = m[idx].act && (e >= m[idx].k) && (e < m[idx].k + 1 + H + gap);
        return o;
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m[i].act  = 1'b0;
                m[i].din  = '0;
                m[i].data = '0;
            end
            qa.push_back('0);
            qb.push_back('0);
        end else begin
            qa.push_back(step(0, G, edge_n, req_s, wd_s, bus_a_s));
            qb.push_back(step(1, 0, edge_n, req_s, wd_s, bus_b_s));
        end
    end

    task automatic cmp(string name, obs_t got, logic has_exp, obs_t exp);
        total++;
        if (!has_exp)
            $display("FAIL %s cyc%0d no expectation queued, got %h", name, edge_n, got);
        else if (got !== exp)
            $display("FAIL %s cyc%0d got din=%h en=%b busy=%b ack=%b err=%b exp din=%h en=%b busy=%b ack=%b err=%b",
                     name, edge_n, got.din, got.en, got.busy, got.ack, got.err,
                     exp.din, exp.en, exp.busy, exp.ack, exp.err);
        else
            passed++;
    endtask

    always @(posedge clk) begin
        obs_t ea, eb;
        #1;
        ea = '0;
        eb = '0;
        if (qa.size() > 0) ea = qa.pop_front();
        cmp("gap2", {din_a, en_a, busy_a, ack_a, err_a}, qa.size() >= 0, ea);
        if (qb.size() > 0) eb = qb.pop_front();
        cmp("gap0", {din_b, en_b, busy_b, ack_b, err_b}, qb.size() >= 0, eb);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle reset: outputs must clear before any further clock edge.
    task automatic async_rst();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({din_a, en_a, busy_a, ack_a, err_a, din_b, en_b, busy_b, ack_b, err_b} !== '0)
            $display("FAIL async_rst got a=%h/%b%b%b%b b=%h/%b%b%b%b exp all zero",
                     din_a, en_a, busy_a, ack_a, err_a, din_b, en_b, busy_b, ack_b, err_b);
        else
            passed++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single transfer, then an ignored request with FF during DRIVE.
        req = 1'b1; wdata = 8'hA5;
        tick();
        req = 1'b0;
        tick(); tick();
        req = 1'b1; wdata = 8'hFF;
        tick();
        req = 1'b0;
        repeat (8) tick();

        // Readback fault.
        fault = 1'b1; fval = 8'h0E;
        req = 1'b1; wdata = 8'h0F;
        tick();
        req = 1'b0;
        repeat (8) tick();
        fault = 1'b0;

        // Held request, back-to-back transfers.
        req = 1'b1; wdata = 8'h01;
        tick();
        wdata = 8'h02;
        repeat (20) tick();
        req = 1'b0;
        repeat (8) tick();

        // Reset during DRIVE, then a normal transfer.
        req = 1'b1; wdata = 8'h77;
        tick();
        req = 1'b0;
        tick(); tick();
        async_rst();
        req = 1'b1; wdata = 8'h3C;
        tick();
        req = 1'b0;
        repeat (10) tick();

        // Random traffic.
        repeat (500) begin
            req   = ($urandom_range(0, 2) != 0);
            wdata = W'($urandom);
            fault = ($urandom_range(0, 5) == 0);
            fval  = W'($urandom);
            if ($urandom_range(0, 79) == 0) async_rst();
            else tick();
        end
        req = 1'b0;
        fault = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
